mem_bus_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the CPU's memory-mapped data window at 0x0500–0x08FF. Shares one synchronous memory between requester 0 (CPU data port) and requester 1 (DMA/peripheral), grants round-robin, and range-checks each request. It drives chip select for a fixed number of wait states and returns a one-cycle acknowledge, or an error acknowledge for out-of-window addresses.

---
 rtl/mem_bus_pkg.sv | 20 ++
 rtl/addr_window.sv | 12 +
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared constants and types for the memory-mapped data window arbiter.
// The window bounds and wait-counter width live here so the sub-module and top stay in step.
package mem_bus_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    localparam logic [31:0] DATA_WIN_BASE  = 32'h0000_0500;
    localparam logic [31:0] DATA_WIN_LIMIT = 32'h0000_08FF;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
    } req_t;

endpackage

// File: rtl/addr_window.sv
// Inclusive range check of a byte address against the data window.
module addr_window #(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0500,
    parameter logic [31:0] LIMIT_ADDR = 32'h0000_08FF
) (
    input  logic [31:0] addr_i,
    output logic        in_win_o
);

    assign in_win_o = (addr_i >= BASE_ADDR) && (addr_i <= LIMIT_ADDR);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-port arbiter and fixed-wait access sequencer for the data window.
// Out-of-window requests are answered with Ack+Err without touching the memory.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_WIN_BASE,
    parameter logic [31:0] LIMIT_ADDR  = DATA_WIN_LIMIT,
    parameter int          WAIT_STATES = 2,
    parameter int          DATA_W      = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Req0,
    input  logic              Req1,
    input  logic [31:0]       Addr0,
    input  logic [31:0]       Addr1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [DATA_W-1:0] WData0,
    input  logic [DATA_W-1:0] WData1,
    output logic              Ack0,
    output logic              Ack1,
    output logic              Err0,
    output logic              Err1,
    output logic [DATA_W-1:0] RData0,
    output logic [DATA_W-1:0] RData1,
    output logic              MemCS,
    output logic              MemWE,
    output logic [31:0]       MemAddr,
    output logic [DATA_W-1:0] MemWData,
    input  logic [DATA_W-1:0] MemRData
);

    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   grant_q, grant_d;
    logic                   last_q, last_d;
    logic [31:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic              win;
    logic              in_win;
    req_t              win_req;
    logic [DATA_W-1:0] win_wdata;

    // Under contention the requester not served last time wins.
    assign win       = (Req0 && Req1) ? ~last_q : Req1;
    assign win_req   = win ? '{addr: Addr1, we: WE1} : '{addr: Addr0, we: WE0};
    assign win_wdata = win ? WData1 : WData0;

    addr_window #(
        .BASE_ADDR (BASE_ADDR),
        .LIMIT_ADDR(LIMIT_ADDR)
    ) u_addr_window (
        .addr_i  (win_req.addr),
        .in_win_o(in_win)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        last_d  = last_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (Req0 || Req1) begin
                    grant_d = win;
                    we_d    = win_req.we;
                    if (in_win) begin
                        addr_d  = win_req.addr - BASE_ADDR;
                        wdata_d = win_wdata;
                        cnt_d   = CNT_W'(WAIT_STATES);
                        state_d = ACCESS;
                    end else begin
                        ack_d[win]   = 1'b1;
                        err_d[win]   = 1'b1;
                        rdata_d[win] = '0;
                        state_d      = ERROR;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    ack_d[grant_q]   = 1'b1;
                    rdata_d[grant_q] = we_q ? '0 : MemRData;
                    state_d          = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                last_d  = grant_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    // Strobes decode straight from state so reset kills them without a clock.
    assign MemCS    = (state_q == ACCESS);
    assign MemWE    = (state_q == ACCESS) && we_q;
    assign MemAddr  = addr_q;
    assign MemWData = wdata_q;

    assign Ack0   = ack_q[0];
    assign Ack1   = ack_q[1];
    assign Err0   = err_q[0];
    assign Err1   = err_q[1];
    assign RData0 = rdata_q[0];
    assign RData1 = rdata_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a transaction table plus hand sequences for
// contention, asynchronous reset abort and a zero-wait-state build.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err0, err1, mcs, mwe;
    logic [31:0] rdata0, rdata1, maddr, mwdata, mrdata;

    logic        z_req0;
    logic [31:0] z_addr0;
    logic        z_ack0, z_ack1, z_err0, z_err1, z_mcs, z_mwe;
    logic [31:0] z_rdata0, z_rdata1, z_maddr, z_mwdata, z_mrdata;

    // Memory model: read data is a fixed function of the offset address.
    assign mrdata   = 32'hCAFE_0001 + maddr;
    assign z_mrdata = 32'hCAFE_0001 + z_maddr;

    mem_bus_arbiter dut (
        .CLK(clk), .RST(rst),
        .Req0(req0), .Req1(req1), .Addr0(addr0), .Addr1(addr1),
        .WE0(we0), .WE1(we1), .WData0(wdata0), .WData1(wdata1),
        .Ack0(ack0), .Ack1(ack1), .Err0(err0), .Err1(err1),
        .RData0(rdata0), .RData1(rdata1),
        .MemCS(mcs), .MemWE(mwe), .MemAddr(maddr), .MemWData(mwdata),
        .MemRData(mrdata)
    );

    mem_bus_arbiter #(.WAIT_STATES(0)) dut_z (
        .CLK(clk), .RST(rst),
        .Req0(z_req0), .Req1(1'b0), .Addr0(z_addr0), .Addr1(32'h0),
        .WE0(1'b0), .WE1(1'b0), .WData0(32'h0), .WData1(32'h0),
        .Ack0(z_ack0), .Ack1(z_ack1), .Err0(z_err0), .Err1(z_err1),
        .RData0(z_rdata0), .RData1(z_rdata1),
        .MemCS(z_mcs), .MemWE(z_mwe), .MemAddr(z_maddr), .MemWData(z_mwdata),
        .MemRData(z_mrdata)
    );

    typedef struct {
        bit          port;
        logic [31:0] addr;
        bit          we;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_maddr;
        logic [31:0] exp_rdata;
        int          exp_cs;
        int          exp_lat;
    } vec_t;

    vec_t vecs[7];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One isolated transaction, started with the DUT in IDLE, ending with it back in IDLE.
    task automatic run_txn(input int idx, input vec_t v);
        int   cs_n = 0;
        int   lat = 0;
        logic path_ok = 1'b1;
        logic other = 1'b0;
        logic a, e;
        logic [31:0] rd;
        if (v.port == 1'b0) begin
            req0 = 1'b1; addr0 = v.addr; we0 = v.we; wdata0 = v.wdata;
        end else begin
            req1 = 1'b1; addr1 = v.addr; we1 = v.we; wdata1 = v.wdata;
        end
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin
                // Request fields need only be valid when first sampled.
                addr0 = 32'h0; addr1 = 32'h0; we0 = ~we0; we1 = ~we1;
                wdata0 = 32'hBAD0_BAD0; wdata1 = 32'hBAD1_BAD1;
            end
            a  = v.port ? ack1 : ack0;
            e  = v.port ? err1 : err0;
            rd = v.port ? rdata1 : rdata0;
            if (mcs) begin
                cs_n++;
                if (maddr !== v.exp_maddr || mwe !== v.we || (v.we && mwdata !== v.wdata))
                    path_ok = 1'b0;
            end
            if (v.port ? ack0 : ack1) other = 1'b1;
            if (a) begin
                lat = n;
                chk($sformatf("v%0d_err", idx), e, v.exp_err);
                chk($sformatf("v%0d_rdata", idx), rd, v.exp_rdata);
            end
        end
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        chk($sformatf("v%0d_ack_latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d_cs_cycles", idx), cs_n, v.exp_cs);
        chk($sformatf("v%0d_mem_path", idx), path_ok, 1);
        chk($sformatf("v%0d_other_ack", idx), other, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int   k, bursts, ord, cs_n, lat;
        logic prev_cs, both, noack;

        vecs[0] = '{1'b0, 32'h0500, 1'b0, 32'h0, 1'b0, 32'h000, 32'hCAFE_0001, 3, 4};
        vecs[1] = '{1'b0, 32'h04FF, 1'b0, 32'h0, 1'b1, 32'h000, 32'h0,         0, 1};
        vecs[2] = '{1'b0, 32'h05FF, 1'b0, 32'h0, 1'b0, 32'h0FF, 32'hCAFE_0100, 3, 4};
        vecs[3] = '{1'b0, 32'h08FF, 1'b0, 32'h0, 1'b0, 32'h3FF, 32'hCAFE_0400, 3, 4};
        vecs[4] = '{1'b0, 32'h0900, 1'b0, 32'h0, 1'b1, 32'h000, 32'h0,         0, 1};
        vecs[5] = '{1'b1, 32'h0700, 1'b1, 32'h1234_5678, 1'b0, 32'h200, 32'h0, 3, 4};
        vecs[6] = '{1'b1, 32'h0600, 1'b0, 32'h0, 1'b0, 32'h100, 32'hCAFE_0101, 3, 4};

        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        z_req0 = 0; z_addr0 = 0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ack_err", {ack0, ack1, err0, err1}, 4'h0);
        chk("reset_rdata0", rdata0, 32'h0);
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_mem_strobes", {mcs, mwe}, 2'b00);
        chk("reset_memaddr", maddr, 32'h0);
        chk("reset_memwdata", mwdata, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

        // Contention from reset release: grants must alternate starting with port 0.
        rst = 1'b1;
        req0 = 1'b1; addr0 = 32'h0500; req1 = 1'b1; addr1 = 32'h0600;
        @(posedge clk); #1;
        rst = 1'b0;
        k = 0; bursts = 0; ord = 0; prev_cs = 1'b0; both = 1'b0;
        for (int n = 0; n < 60 && k < 4; n++) begin
            @(posedge clk); #1;
            if (mcs && !prev_cs) bursts++;
            prev_cs = mcs;
            if (ack0 && ack1) both = 1'b1;
            if (ack0) begin
                ord = (ord << 1); k++;
                chk("cont_rdata0", rdata0, 32'hCAFE_0001);
            end else if (ack1) begin
                ord = (ord << 1) | 1; k++;
                chk("cont_rdata1", rdata1, 32'hCAFE_0101);
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("cont_ack_count", k, 4);
        chk("cont_grant_order", ord, 4'b0101);
        chk("cont_cs_bursts", bursts, 4);
        chk("cont_dual_ack", both, 0);
        @(posedge clk); #1;

        // Abort a write during its second chip-select cycle.
        req1 = 1'b1; addr1 = 32'h0700; we1 = 1'b1; wdata1 = 32'h1234_5678;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_pre_strobes", {mcs, mwe}, 2'b11);
        #2 rst = 1'b1;
        #1;
        chk("abort_async_drop", {mcs, mwe}, 2'b00);
        req1 = 1'b0; we1 = 1'b0;
        noack = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 || ack1) noack = 1'b0;
        end
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack0 || ack1) noack = 1'b0;
        end
        chk("abort_no_ack", noack, 1);
        run_txn(7, vecs[0]);

        // Zero-wait-state build: one chip-select cycle, Ack right after it.
        z_req0 = 1'b1; z_addr0 = 32'h0800;
        cs_n = 0; lat = 0;
        for (int n = 1; n <= 10 && lat == 0; n++) begin
            @(posedge clk); #1;
            if (z_mcs) begin
                cs_n++;
                chk("z_memaddr", z_maddr, 32'h300);
            end
            if (z_ack0) begin
                lat = n;
                chk("z_rdata0", z_rdata0, 32'hCAFE_0301);
                chk("z_err0", z_err0, 1'b0);
            end
        end
        z_req0 = 1'b0;
        chk("z_cs_cycles", cs_n, 1);
        chk("z_ack_latency", lat, 2);
        chk("z_idle_outputs", {z_ack1, z_err1, z_mwe, |z_rdata1, |z_mwdata}, 5'b0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
